// File: rtl/ready_scoreboard.sv
// ready_scoreboard: speculative and retired physical-register ready vectors
// with a circular buffer of branch checkpoints for mispredict recovery.
// Optional feature: define READY_SB_BYPASS_EN to make a tag completing on the
// CDB this cycle read as ready in the same cycle. When it is undefined, reads
// see only the registered speculative vector.
module ready_scoreboard #(
    parameter int WAYS  = 4,
    parameter int PRF   = 64,
    parameter int ARCH  = 32,
    parameter int NCKPT = 4,
    localparam int TW   = $clog2(PRF),
    localparam int CW   = $clog2(NCKPT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 except,
    input  logic [WAYS*TW-1:0]   rda_idx,
    input  logic [WAYS*TW-1:0]   rdb_idx,
    output logic [WAYS-1:0]      rda_ready,
    output logic [WAYS-1:0]      rdb_ready,
    input  logic [WAYS*TW-1:0]   rat_idx,
    input  logic [WAYS-1:0]      rat_en,
    input  logic [WAYS*TW-1:0]   cdb_idx,
    input  logic [WAYS-1:0]      cdb_en,
    input  logic [WAYS*TW-1:0]   ret_new_idx,
    input  logic [WAYS*TW-1:0]   ret_old_idx,
    input  logic [WAYS-1:0]      ret_en,
    input  logic                 ckpt_alloc,
    output logic [CW-1:0]        ckpt_id,
    output logic                 ckpt_full,
    output logic [CW:0]          ckpt_count,
    input  logic                 ckpt_free,
    input  logic                 ckpt_restore,
    input  logic [CW-1:0]        ckpt_restore_id,
    output logic [PRF-1:0]       spec_vec,
    output logic [PRF-1:0]       ret_vec
);

    localparam logic [PRF-1:0] ARCH_INIT = PRF'({ARCH{1'b1}});
    localparam logic [CW:0]    FULL_CNT  = (CW+1)'(NCKPT);

    logic [PRF-1:0] spec_q, spec_d;
    logic [PRF-1:0] ret_q, ret_d;
    logic [CW-1:0]  head_q, head_d;
    logic [CW-1:0]  tail_q, tail_d;
    logic [CW:0]    count_q, count_d;
    logic [PRF-1:0] snap_q [NCKPT];

    logic [PRF-1:0] cdb_mask_s, rat_mask_s, new_mask_s, old_mask_s;
    logic [PRF-1:0] spec_next_s, ret_next_s, read_vec_s;
    logic [CW-1:0]  restore_off_s;
    logic           full_s, restore_ok_s, free_ok_s, alloc_ok_s;

    // Decode the per-way tag ports into one-hot-per-tag masks.
    always_comb begin
        cdb_mask_s = '0;
        rat_mask_s = '0;
        new_mask_s = '0;
        old_mask_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            cdb_mask_s = cdb_mask_s | (PRF'(cdb_en[w]) << cdb_idx[w*TW +: TW]);
            rat_mask_s = rat_mask_s | (PRF'(rat_en[w]) << rat_idx[w*TW +: TW]);
            new_mask_s = new_mask_s | (PRF'(ret_en[w]) << ret_new_idx[w*TW +: TW]);
            old_mask_s = old_mask_s | (PRF'(ret_en[w]) << ret_old_idx[w*TW +: TW]);
        end
        // Rename clears after completion sets; retire sets after old clears.
        spec_next_s = (spec_q | cdb_mask_s) & ~rat_mask_s;
        ret_next_s  = (ret_q & ~old_mask_s) | new_mask_s;
    end

    // Qualify checkpoint requests against the live range of the buffer.
    always_comb begin
        full_s        = (count_q == FULL_CNT);
        restore_off_s = ckpt_restore_id - head_q;
        // A restore id is live when its distance from head is below count.
        restore_ok_s  = ckpt_restore && ({1'b0, restore_off_s} < count_q);
        free_ok_s     = ckpt_free && (count_q != {(CW+1){1'b0}});
        alloc_ok_s    = ckpt_alloc && !full_s && !restore_ok_s && !except;
    end

    // Next-state selection: exception, then valid restore, then normal update.
    always_comb begin
        ret_d = ret_next_s;
        if (except) begin
            spec_d  = ret_next_s;
            head_d  = tail_q;
            tail_d  = tail_q;
            count_d = '0;
        end else if (restore_ok_s) begin
            spec_d = snap_q[ckpt_restore_id] | cdb_mask_s;
            tail_d = ckpt_restore_id;
            if (free_ok_s) begin
                if (restore_off_s == {CW{1'b0}}) begin
                    // Freeing and restoring the oldest both discard it.
                    head_d  = ckpt_restore_id;
                    count_d = '0;
                end else begin
                    head_d  = head_q + {{(CW-1){1'b0}}, 1'b1};
                    count_d = {1'b0, restore_off_s - {{(CW-1){1'b0}}, 1'b1}};
                end
            end else begin
                head_d  = head_q;
                count_d = {1'b0, restore_off_s};
            end
        end else begin
            // A restore to a dead id is dropped entirely.
            spec_d  = spec_next_s;
            head_d  = free_ok_s ? head_q + {{(CW-1){1'b0}}, 1'b1} : head_q;
            tail_d  = alloc_ok_s ? tail_q + {{(CW-1){1'b0}}, 1'b1} : tail_q;
            count_d = count_q + (CW+1)'(alloc_ok_s) - (CW+1)'(free_ok_s);
        end
    end

    // Ready vectors and buffer pointers, synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            spec_q  <= ARCH_INIT;
            ret_q   <= ARCH_INIT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            spec_q  <= spec_d;
            ret_q   <= ret_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Snapshots absorb every completion; a granted alloc captures spec_next.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NCKPT; i++) begin
            snap_q[i] <= snap_q[i] | cdb_mask_s;
        end
        if (alloc_ok_s && !reset) begin
            snap_q[tail_q] <= spec_next_s;
        end
    end

`ifdef READY_SB_BYPASS_EN
    assign read_vec_s = spec_q | cdb_mask_s;
`else
    assign read_vec_s = spec_q;
`endif

    // Source-tag ready lookups.
    always_comb begin
        rda_ready = '0;
        rdb_ready = '0;
        for (int w = 0; w < WAYS; w++) begin
            rda_ready[w] = read_vec_s[rda_idx[w*TW +: TW]];
            rdb_ready[w] = read_vec_s[rdb_idx[w*TW +: TW]];
        end
    end

    assign spec_vec   = spec_q;
    assign ret_vec    = ret_q;
    assign ckpt_id    = tail_q;
    assign ckpt_count = count_q;
    assign ckpt_full  = full_s;

endmodule

// File: tb/tb_ready_scoreboard.sv
// Self-checking bench for ready_scoreboard: directed scenarios plus a short
// pseudo-random run, checked every cycle against a queue-based model.
module tb_ready_scoreboard;

    localparam int WAYS = 4, PRF = 64, ARCH = 32, NCKPT = 4;
    localparam int TW = $clog2(PRF), CW = $clog2(NCKPT);
`ifdef READY_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, except;
    logic [WAYS*TW-1:0] rda_idx, rdb_idx, rat_idx, cdb_idx, ret_new_idx, ret_old_idx;
    logic [WAYS-1:0] rda_ready, rdb_ready, rat_en, cdb_en, ret_en;
    logic ckpt_alloc, ckpt_full, ckpt_free, ckpt_restore;
    logic [CW-1:0] ckpt_id, ckpt_restore_id;
    logic [CW:0] ckpt_count;
    logic [PRF-1:0] spec_vec, ret_vec;

    ready_scoreboard #(.WAYS(WAYS), .PRF(PRF), .ARCH(ARCH), .NCKPT(NCKPT)) dut (
        .clock(clock), .reset(reset), .except(except),
        .rda_idx(rda_idx), .rdb_idx(rdb_idx), .rda_ready(rda_ready), .rdb_ready(rdb_ready),
        .rat_idx(rat_idx), .rat_en(rat_en), .cdb_idx(cdb_idx), .cdb_en(cdb_en),
        .ret_new_idx(ret_new_idx), .ret_old_idx(ret_old_idx), .ret_en(ret_en),
        .ckpt_alloc(ckpt_alloc), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
        .ckpt_count(ckpt_count), .ckpt_free(ckpt_free), .ckpt_restore(ckpt_restore),
        .ckpt_restore_id(ckpt_restore_id), .spec_vec(spec_vec), .ret_vec(ret_vec)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef struct { int id; bit [PRF-1:0] v; } ck_t;
    bit [PRF-1:0] m_spec, m_ret;
    ck_t m_q[$];
    int m_tail;

    always @(posedge clock) begin
        bit [PRF-1:0] cm, rm, om, nm, sn, rn;
        int k, pop;
        bit do_alloc;
        ck_t nq[$];
        ck_t e;
        if (reset) begin
            m_spec = '0;
            for (int i = 0; i < ARCH; i++) m_spec[i] = 1'b1;
            m_ret = m_spec;
            m_q.delete();
            m_tail = 0;
        end else begin
            cm = '0; rm = '0; om = '0; nm = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (cdb_en[w]) cm[cdb_idx[w*TW +: TW]] = 1'b1;
                if (rat_en[w]) rm[rat_idx[w*TW +: TW]] = 1'b1;
                if (ret_en[w]) begin
                    om[ret_old_idx[w*TW +: TW]] = 1'b1;
                    nm[ret_new_idx[w*TW +: TW]] = 1'b1;
                end
            end
            rn = (m_ret & ~om) | nm;
            sn = (m_spec | cm) & ~rm;
            foreach (m_q[i]) m_q[i].v = m_q[i].v | cm;
            if (except) begin
                m_spec = rn;
                m_q.delete();
            end else begin
                k = -1;
                if (ckpt_restore) foreach (m_q[i]) if (m_q[i].id == int'(ckpt_restore_id)) k = i;
                pop = (ckpt_free && m_q.size() > 0) ? 1 : 0;
                if (k >= 0) begin
                    m_spec = m_q[k].v;
                    nq.delete();
                    for (int i = pop; i < k; i++) nq.push_back(m_q[i]);
                    m_q = nq;
                    m_tail = int'(ckpt_restore_id);
                end else begin
                    do_alloc = ckpt_alloc && (m_q.size() < NCKPT);
                    m_spec = sn;
                    if (pop == 1) void'(m_q.pop_front());
                    if (do_alloc) begin
                        e.id = m_tail; e.v = sn;
                        m_q.push_back(e);
                        m_tail = (m_tail + 1) % NCKPT;
                    end
                end
            end
            m_ret = rn;
        end
    end

    // ---------------- checking ----------------
    typedef struct { string name; int kind; int idx; logic [63:0] val; } exp_t;
    exp_t eq[$];
    int n_checks = 0, n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit cdb_hit(input logic [TW-1:0] t);
        bit h = 1'b0;
        for (int v = 0; v < WAYS; v++) if (cdb_en[v] && cdb_idx[v*TW +: TW] == t) h = 1'b1;
        return h;
    endfunction

    always @(negedge clock) begin
        exp_t x;
        logic [63:0] act;
        if (!reset && chk_en) begin
            chk("model_spec_vec", spec_vec, m_spec);
            chk("model_ret_vec", ret_vec, m_ret);
            chk("model_count", 64'(ckpt_count), 64'(m_q.size()));
            chk("model_full", 64'(ckpt_full), 64'(m_q.size() == NCKPT));
            chk("model_id", 64'(ckpt_id), 64'(m_tail));
            for (int w = 0; w < WAYS; w++) begin
                chk("model_rda_ready", 64'(rda_ready[w]),
                    64'(m_spec[rda_idx[w*TW +: TW]] | (BYP & cdb_hit(rda_idx[w*TW +: TW]))));
                chk("model_rdb_ready", 64'(rdb_ready[w]),
                    64'(m_spec[rdb_idx[w*TW +: TW]] | (BYP & cdb_hit(rdb_idx[w*TW +: TW]))));
            end
        end
        while (eq.size() > 0) begin
            x = eq.pop_front();
            case (x.kind)
                0: act = spec_vec;
                1: act = ret_vec;
                2: act = 64'(ckpt_count);
                3: act = 64'(ckpt_full);
                4: act = 64'(ckpt_id);
                5: act = 64'(rda_ready[0]);
                6: act = 64'(spec_vec[x.idx]);
                default: act = 'x;
            endcase
            chk(x.name, act, x.val);
        end
    end

    task automatic expect_v(input string n, input int k, input int i, input logic [63:0] v);
        exp_t x;
        x.name = n; x.kind = k; x.idx = i; x.val = v;
        eq.push_back(x);
    endtask

    task automatic idle();
        except = 1'b0; rat_en = '0; cdb_en = '0; ret_en = '0;
        ckpt_alloc = 1'b0; ckpt_free = 1'b0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
        rda_idx = '0; rdb_idx = '0; rat_idx = '0; cdb_idx = '0;
        ret_new_idx = '0; ret_old_idx = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        expect_v("reset_spec", 0, 0, 64'h0000_0000_FFFF_FFFF);
        expect_v("reset_ret", 1, 0, 64'h0000_0000_FFFF_FFFF);
        expect_v("reset_count", 2, 0, 64'd0);
        expect_v("reset_full", 3, 0, 64'd0);

        // Rename 40, then complete 40 while reading it.
        rat_en[0] = 1'b1; rat_idx[0*TW +: TW] = 6'd40;
        tick();
        expect_v("rename40_notready", 6, 40, 64'd0);
        cdb_en[1] = 1'b1; cdb_idx[1*TW +: TW] = 6'd40; rda_idx[0*TW +: TW] = 6'd40;
        expect_v("cdb40_same_cycle", 5, 0, BYP ? 64'd1 : 64'd0);
        tick();
        rda_idx[0*TW +: TW] = 6'd40;
        expect_v("cdb40_next_cycle", 5, 0, 64'd1);
        tick();

        // Same-cycle rename and completion of 60: rename wins.
        rat_en[2] = 1'b1; rat_idx[2*TW +: TW] = 6'd60;
        cdb_en[2] = 1'b1; cdb_idx[2*TW +: TW] = 6'd60;
        tick();
        expect_v("rat_cdb60", 6, 60, 64'd0);

        // Checkpoint restore keeps completions that occurred after the snapshot.
        cdb_en[0] = 1'b1; cdb_idx[0*TW +: TW] = 6'd50;
        tick();
        ckpt_alloc = 1'b1; rat_en[0] = 1'b1; rat_idx[0*TW +: TW] = 6'd45;
        expect_v("alloc_id0", 4, 0, 64'd0);
        tick();
        expect_v("alloc_count1", 2, 0, 64'd1);
        expect_v("tag45_notready", 6, 45, 64'd0);
        rat_en[1] = 1'b1; rat_idx[1*TW +: TW] = 6'd50;
        tick();
        expect_v("tag50_renamed", 6, 50, 64'd0);
        cdb_en[3] = 1'b1; cdb_idx[3*TW +: TW] = 6'd45;
        tick();
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
        rat_en[0] = 1'b1; rat_idx[0*TW +: TW] = 6'd7;
        tick();
        expect_v("restore_tag45", 6, 45, 64'd1);
        expect_v("restore_tag50", 6, 50, 64'd1);
        expect_v("restore_rat_ignored", 6, 7, 64'd1);
        expect_v("restore_count0", 2, 0, 64'd0);

        // Fill the buffer: four grants, fifth dropped.
        for (int i = 0; i < 5; i++) begin
            ckpt_alloc = 1'b1;
            expect_v("alloc_id", 4, 0, 64'(i % NCKPT));
            tick();
        end
        expect_v("fill_full", 3, 0, 64'd1);
        expect_v("fill_count", 2, 0, 64'd4);

        // Restore id 2 together with freeing the oldest: id 1 survives.
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd2; ckpt_free = 1'b1;
        tick();
        expect_v("restore_free_count", 2, 0, 64'd1);
        expect_v("restore_free_id", 4, 0, 64'd2);
        ckpt_free = 1'b1;
        tick();
        expect_v("free_to_empty", 2, 0, 64'd0);
        ckpt_free = 1'b1;
        tick();
        expect_v("free_when_empty", 2, 0, 64'd0);
        ckpt_restore = 1'b1; ckpt_restore_id = 2'd1;
        tick();
        expect_v("dead_restore_count", 2, 0, 64'd0);

        // Retire with exception.
        ckpt_alloc = 1'b1;
        tick();
        ret_en[0] = 1'b1; ret_new_idx[0*TW +: TW] = 6'd33; ret_old_idx[0*TW +: TW] = 6'd5;
        except = 1'b1; ckpt_alloc = 1'b1; ckpt_restore = 1'b1; ckpt_restore_id = 2'd2;
        tick();
        expect_v("except_ret", 1, 0, 64'h0000_0002_FFFF_FFDF);
        expect_v("except_spec", 0, 0, 64'h0000_0002_FFFF_FFDF);
        expect_v("except_count", 2, 0, 64'd0);

        // Pseudo-random traffic checked against the model.
        for (int c = 0; c < 400; c++) begin
            for (int w = 0; w < WAYS; w++) begin
                rat_en[w] = ($urandom_range(0, 3) == 0);
                cdb_en[w] = ($urandom_range(0, 2) == 0);
                ret_en[w] = ($urandom_range(0, 5) == 0);
                rat_idx[w*TW +: TW] = 6'($urandom_range(0, PRF-1));
                cdb_idx[w*TW +: TW] = 6'($urandom_range(0, PRF-1));
                ret_new_idx[w*TW +: TW] = 6'($urandom_range(0, PRF-1));
                ret_old_idx[w*TW +: TW] = 6'($urandom_range(0, PRF-1));
                rda_idx[w*TW +: TW] = 6'($urandom_range(0, PRF-1));
                rdb_idx[w*TW +: TW] = 6'($urandom_range(0, PRF-1));
            end
            ckpt_alloc = ($urandom_range(0, 2) == 0);
            ckpt_free = ($urandom_range(0, 4) == 0);
            ckpt_restore = ($urandom_range(0, 6) == 0);
            ckpt_restore_id = 2'($urandom_range(0, NCKPT-1));
            except = ($urandom_range(0, 40) == 0);
            tick();
        end
        tick();
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
